// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Build option: define ALU_ACCUM_EN so a load in DONE reuses the previous result as operand A.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    // Bit positions inside the packed flag vector
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        EXEC   = 2'b10,
        DONE   = 2'b11
    } state_e;

    typedef logic [FLAG_W-1:0] flags_t;

    // Pack adder status into the flag vector; zero/negative derive from the sum alone
    function automatic flags_t make_flags(input logic [ALU_WIDTH-1:0] sum,
                                          input logic                 cout,
                                          input logic                 ov);
        flags_t f;
        f         = '0;
        f[FLAG_C] = cout;
        f[FLAG_V] = ov;
        f[FLAG_Z] = (sum == '0);
        f[FLAG_N] = sum[ALU_WIDTH-1];
        return f;
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Board-side and adder-side signal bundle for the ALU operand sequencer.
interface alu_operand_sequencer_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
);
    logic [WIDTH-1:0] sw_in;
    logic             btn_load;
    logic             btn_clear;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;
    logic             ov_in;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_v;
    logic             flag_z;
    logic             flag_n;
    logic             valid;
    logic [1:0]       state_o;

    // Sequencer side
    modport slave (
        input  sw_in, btn_load, btn_clear, sum_in, cout_in, ov_in,
        output op_a, op_b, result, flag_c, flag_v, flag_z, flag_n, valid, state_o
    );

    // Board, adder and display side
    modport master (
        output sw_in, btn_load, btn_clear, sum_in, cout_in, ov_in,
        input  op_a, op_b, result, flag_c, flag_v, flag_z, flag_n, valid, state_o
    );
endinterface

// File: rtl/alu_operand_sequencer_edge_detect.sv
// Rising-edge pulse generator for an already synchronised level input.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse_c
);
    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse_c = level & ~level_q;
endmodule

// File: rtl/alu_operand_sequencer.sv
// Captures adder operands on load presses and latches the adder result and flags.
// Build option: ALU_ACCUM_EN makes a load in DONE take operand A from the previous result.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_operand_sequencer_if.slave  bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;
    logic             valid_q, valid_d;
    logic             load_p;

    edge_detect u_load_edge (
        .clk     (clk),
        .rst     (rst),
        .level   (bus.btn_load),
        .pulse_c (load_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state and datapath update; clear overrides everything, including a load edge
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = valid_q;

        unique case (state_q)
            WAIT_A: begin
                if (load_p) begin
                    op_a_d  = bus.sw_in;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (load_p) begin
                    op_b_d  = bus.sw_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = bus.sum_in;
                flags_d  = make_flags(bus.sum_in, bus.cout_in, bus.ov_in);
                valid_d  = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (load_p) begin
`ifdef ALU_ACCUM_EN
                    op_a_d = result_q;
`else
                    op_a_d = bus.sw_in;
`endif
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
            end
            default: state_d = WAIT_A;
        endcase

        if (bus.btn_clear) begin
            state_d  = WAIT_A;
            op_a_d   = '0;
            op_b_d   = '0;
            result_d = '0;
            flags_d  = '0;
            valid_d  = 1'b0;
        end
    end

    assign bus.op_a    = op_a_q;
    assign bus.op_b    = op_b_q;
    assign bus.result  = result_q;
    assign bus.flag_c  = flags_q[FLAG_C];
    assign bus.flag_v  = flags_q[FLAG_V];
    assign bus.flag_z  = flags_q[FLAG_Z];
    assign bus.flag_n  = flags_q[FLAG_N];
    assign bus.valid   = valid_q;
    assign bus.state_o = state_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a behavioural 8-bit adder.
module tb_alu_operand_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_operand_sequencer_if bus ();

    alu_operand_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ripple-carry adder stand-in
    logic [8:0] add_full;
    assign add_full    = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    assign bus.sum_in  = add_full[7:0];
    assign bus.cout_in = add_full[8];
    assign bus.ov_in   = (bus.op_a[7] == bus.op_b[7]) && (add_full[7] != bus.op_a[7]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare against the scoreboard whenever a new result becomes valid
    initial begin : monitor
        logic vprev;
        exp_t e;
        vprev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.valid === 1'b1 && vprev !== 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid: got result %0h with empty scoreboard", bus.result);
                end else begin
                    e = sb.pop_front();
                    check("result", 32'(bus.result), 32'(e.res));
                    check("flags_cvzn", 32'({bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}),
                          32'({e.c, e.v, e.z, e.n}));
                end
            end
            vprev = bus.valid;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_state"},  32'(bus.state_o), 32'(2'b00));
        check({tag, "_op_a"},   32'(bus.op_a), 32'h0);
        check({tag, "_op_b"},   32'(bus.op_b), 32'h0);
        check({tag, "_result"}, 32'(bus.result), 32'h0);
        check({tag, "_flags"},  32'({bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}), 32'h0);
        check({tag, "_valid"},  32'(bus.valid), 32'h0);
    endtask

    task automatic press(input logic [7:0] v);
        @(negedge clk);
        bus.sw_in    = v;
        bus.btn_load = 1'b1;
        @(negedge clk);
        bus.btn_load = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.btn_clear = 1'b1;
        @(negedge clk);
        bus.btn_clear = 1'b0;
        check_idle("clear");
    endtask

    // After the B press edge: EXEC for one cycle, then DONE with valid
    task automatic finish_op(input logic [7:0] b);
        check("op_b", 32'(bus.op_b), 32'(b));
        check("exec_state", 32'(bus.state_o), 32'(2'b10));
        check("exec_valid", 32'(bus.valid), 32'h0);
        @(negedge clk);
        check("done_state", 32'(bus.state_o), 32'(2'b11));
        check("done_valid", 32'(bus.valid), 32'h1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] res,
                          input logic c, input logic v, input logic z, input logic n);
        exp_t e;
        press(a);
        check("op_a", 32'(bus.op_a), 32'(a));
        check("wait_b_state", 32'(bus.state_o), 32'(2'b01));
        e.res = res; e.c = c; e.v = v; e.z = z; e.n = n;
        sb.push_back(e);
        press(b);
        finish_op(b);
    endtask

    initial begin : stimulus
        exp_t e;
        logic [7:0] exp_op_a;
        logic [7:0] exp_res;
        rst           = 1'b1;
        bus.sw_in     = '0;
        bus.btn_load  = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        do_clear();
        run_op(8'd100, 8'd27, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        do_clear();
        run_op(8'd100, 8'd28, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        do_clear();
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        do_clear();
        run_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

        // Held load in DONE: only the first edge acts
        do_clear();
        run_op(8'd5, 8'd3, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_ACCUM_EN
        exp_op_a = 8'd8;
        exp_res  = 8'd10;
`else
        exp_op_a = 8'd2;
        exp_res  = 8'd4;
`endif
        @(negedge clk);
        bus.sw_in    = 8'd2;
        bus.btn_load = 1'b1;
        repeat (10) @(negedge clk);
        check("hold_state", 32'(bus.state_o), 32'(2'b01));
        check("hold_op_a", 32'(bus.op_a), 32'(exp_op_a));
        check("hold_op_b", 32'(bus.op_b), 32'(8'd3));
        check("hold_valid", 32'(bus.valid), 32'h0);
        check("hold_result", 32'(bus.result), 32'(8'd8));
        bus.btn_load = 1'b0;
        e.res = exp_res; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0; e.n = 1'b0;
        sb.push_back(e);
        press(8'd2);
        finish_op(8'd2);

        // Clear wins over a simultaneous load edge in WAIT_B
        do_clear();
        press(8'd9);
        @(negedge clk);
        bus.sw_in     = 8'd77;
        bus.btn_load  = 1'b1;
        bus.btn_clear = 1'b1;
        @(negedge clk);
        bus.btn_load  = 1'b0;
        bus.btn_clear = 1'b0;
        check_idle("clear_load");

        // Reset during EXEC aborts without latching a result
        press(8'd10);
        press(8'd20);
        check("pre_rst_state", 32'(bus.state_o), 32'(2'b10));
        #2 rst = 1'b1;
        #1 check_idle("rst_exec");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("post_rst");
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Sequential front/back-end for the 8-bit ripple-carry adder. It captures operands A and B from the board switches on successive debounced "load" button presses and drives them onto the adder inputs. It then latches the adder's sum, carry-out and overflow together with derived zero/negative flags into a stable result register for the display stage. It is the only clocked logic between the switch/button inputs and the combinational adder.

## Interface
Parameters:
- WIDTH, 8, operand/result width; must match the adder (only 8 supported).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sw_in  input  WIDTH  operand value from switches
- btn_load  input  1  load button, already synchronised and debounced, level
- btn_clear  input  1  synchronous clear request, level
- op_a  output  WIDTH  registered operand A, wired to adder A
- op_b  output  WIDTH  registered operand B, wired to adder B
- sum_in  input  WIDTH  adder S
- cout_in  input  1  adder Cout
- ov_in  input  1  adder OV
- result  output  WIDTH  latched sum
- flag_c, flag_v, flag_z, flag_n  output  1 each  latched carry, overflow, zero, negative
- valid  output  1  result/flags hold a completed addition
- state_o  output  2  current FSM state, for LEDs

## Operation
- Load edge: `load_p = btn_load & ~btn_load_q`. `btn_load_q` is a register. Only edges act; holding the button does nothing further.
- States: WAIT_A (00), WAIT_B (01), EXEC (10), DONE (11).
- WAIT_A, on load_p: `op_a <= sw_in` and go to WAIT_B.
- WAIT_B, on load_p: `op_b <= sw_in` and go to EXEC.
- EXEC lasts exactly one cycle and ignores load_p. On exit it latches:
  - `result <= sum_in`, `flag_c <= cout_in`, `flag_v <= ov_in`
  - `flag_z <= (sum_in == 0)`, `flag_n <= sum_in[WIDTH-1]`
  - `valid <= 1`, then goes to DONE.
- DONE, on load_p: `op_a <= sw_in`, `op_b` unchanged, `valid <= 0`, go to WAIT_B. See the Configuration section for the ACCUM_EN variant.
- btn_clear, any state: next clock edge sets `op_a`, `op_b`, `result` and all flags to 0, `valid = 0`, state WAIT_A.
- Clear has priority over a simultaneous load_p.
- Arithmetic is entirely in the adder. This block never alters `sum_in`.
- Flags are latched exactly as the adder presents them during EXEC.

## Timing
- Reset (async assert, values held while rst = 1):
  - state = WAIT_A
  - `op_a`, `op_b`, `result`, flags, `valid`, `btn_load_q` all 0
- Reset mid-EXEC aborts the operation and no result is latched.
- Capture latency: operand registers update on the first clock edge where load_p = 1.
- Result latency: load_p for B at edge k means `op_b` is valid after k. EXEC runs during cycle k..k+1. `result`, flags and `valid` are valid after edge k+1, which is 2 edges after the B press edge is sampled.
- The adder path (`op_a`/`op_b` → `sum_in`) must settle within one clock. It is a single-cycle combinational path with no multicycle constraint.
- `result` and flags are stable from DONE entry until the next EXEC exit or clear.

## Configuration
- `ALU_ACCUM_EN` defined: a load_p in DONE sets `op_a <= result` (not `sw_in`). Chained additions therefore accumulate, and the next press enters B as usual.
- Undefined: a load_p in DONE sets `op_a <= sw_in`, as described in Operation.
- All other behaviour is identical in both builds.

## Structure
- Package `alu_pkg`:
  - state encoding constants (WAIT_A, WAIT_B, EXEC, DONE as 2-bit values)
  - ALU_WIDTH = 8
  - flag bit indices for a packed flag vector (C=0, V=1, Z=2, N=3)
- Sub-module `edge_detect` produces the single-cycle pulse from a level input. It is instantiated for btn_load and is reusable for future buttons.
- The adder is instantiated at the top level, not inside this block.

## Test plan
- Sequence 100 then 27 → result 127, C=0 V=0 Z=0 N=0, valid high 2 edges after the second press.
- Sequence 100 then 28 → result 0x80, V=1 N=1 C=0 Z=0.
- Sequence 0xFF then 0x01 → result 0x00, C=1 Z=1 V=0 N=0.
- Sequence 5, 3, then hold btn_load 10 cycles in DONE followed by one further press with sw_in = 2:
  - only one load_p acts
  - with `ALU_ACCUM_EN` defined: `op_a` = 8, second operand 2 → result 10
  - without the macro: `op_a` = 2
- Clear asserted together with load_p in WAIT_B, and separately rst asserted during EXEC → both return to WAIT_A with all outputs 0 and valid = 0.
